// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream_demux block.
// STREAM_DEMUX_CNT_EN (see stream_demux.sv) makes use of CNT_W.
package stream_demux_pkg;

  localparam int unsigned CNT_W = 16;

  // Select width: max(1, clog2(n)).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single demux channel.
// A load overrides a same-cycle drain, which keeps throughput at one word per cycle.
module demux_slot #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N valid/ready stream demultiplexer with a one-entry register per channel.
// Optional macro STREAM_DEMUX_CNT_EN adds port cnt with saturating per-channel delivery counters.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int unsigned W         = 2,
  parameter  int unsigned N         = 2,
  parameter  bit          ZERO_IDLE = 1'b1,
  localparam int unsigned SW        = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic           err_oob
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [N*CNT_W-1:0] cnt
`endif
);

  localparam logic [SW:0] NCH = (SW+1)'(N);

  logic [N-1:0] valid_q;
  logic [W-1:0] data_q [N];
  logic [N-1:0] load;
  logic         in_range;
  logic         ready_sel;
  logic         err_oob_q, err_oob_d;

  // An out-of-range select matches no channel, so it is always accepted and dropped.
  always_comb begin
    in_range  = ({1'b0, in_sel} < NCH);
    ready_sel = 1'b1;
    load      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_sel == SW'(i)) begin
        ready_sel = !valid_q[i] || out_ready[i];
        load[i]   = in_valid && (!valid_q[i] || out_ready[i]);
      end
    end
    err_oob_d = in_valid && !in_range;
  end

  assign in_ready = ready_sel;

  for (genvar g = 0; g < N; g++) begin : g_slot
    demux_slot #(
      .W (W)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .d     (in_data),
      .ready (out_ready[g]),
      .q     (data_q[g]),
      .valid (valid_q[g])
    );

    assign out_data[g*W +: W] = (ZERO_IDLE && !valid_q[g]) ? '0 : data_q[g];
  end

  assign out_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_oob_q <= 1'b0;
    end else begin
      err_oob_q <= err_oob_d;
    end
  end

  assign err_oob = err_oob_q;

`ifdef STREAM_DEMUX_CNT_EN
  for (genvar g = 0; g < N; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (valid_q[g] && out_ready[g] && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt[g*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter W, default 2, giving the data width per channel in bits (W >= 1).
REQ-002 The block SHALL have parameter N, default 2, giving the number of output channels (2..16).
REQ-003 The block SHALL have parameter ZERO_IDLE, default 1: when 1, a channel's data slice reads 0 while its valid is low; when 0, the slice holds its last value.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_data, input, W bits: input word.
REQ-007 The block SHALL have port in_sel, input, SW = max(1, clog2(N)) bits: destination channel index.
REQ-008 The block SHALL have port in_valid, input, 1 bit: input word and select are valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-010 The block SHALL have port out_data, output, N*W bits: channel i occupies bits [i*W +: W].
REQ-011 The block SHALL have port out_valid, output, N bits: per-channel valid.
REQ-012 The block SHALL have port out_ready, input, N bits: per-channel downstream ready.
REQ-013 The block SHALL have port err_oob, output, 1 bit: one-cycle pulse flagging that an out-of-range select was accepted.

Function
REQ-014 Transfers SHALL use a valid/ready handshake; a transfer occurs on a cycle where valid and ready are both high.
REQ-015 Each channel SHALL have a one-entry output register holding data_q[i] and valid_q[i]; out_valid[i] SHALL equal valid_q[i].
REQ-016 For in_sel < N, in_ready SHALL be combinational and equal !valid_q[in_sel] || out_ready[in_sel]; it SHALL NOT depend on any other channel.
REQ-017 An accepted word SHALL appear on channel in_sel with out_valid high exactly 1 cycle after acceptance.
REQ-018 When out_valid[i] and out_ready[i] are both high and no new word targets channel i in that cycle, valid_q[i] SHALL clear on the next edge.
REQ-019 When a channel drains and is reloaded in the same cycle, valid_q[i] SHALL stay high and data_q[i] SHALL take the new word, giving full throughput of 1 word per cycle per channel.
REQ-020 While out_valid[i] is high and out_ready[i] is low, out_data for channel i SHALL remain stable.
REQ-021 For in_sel >= N (possible only when N is not a power of 2), in_ready SHALL be 1; the word SHALL be discarded and err_oob SHALL pulse high for 1 cycle on the following cycle.
REQ-022 Only the selected channel SHALL change state on a transfer; all other channels SHALL keep data and valid.
REQ-023 The ZERO_IDLE masking SHALL be combinational on the output and SHALL NOT alter data_q.

Reset
REQ-024 While rst_n is low, all valid_q, data_q and err_oob SHALL be 0 immediately, regardless of clk.
REQ-025 A word held in a channel register when reset asserts SHALL be lost.
REQ-026 After rst_n deasserts, in_ready SHALL be 1 for any in-range select.

Configuration
REQ-027 Macro STREAM_DEMUX_CNT_EN SHALL add output port cnt, N*16 bits, holding per-channel 16-bit counters of words delivered (out_valid && out_ready).
REQ-028 With STREAM_DEMUX_CNT_EN defined, each counter SHALL saturate at 16'hFFFF and SHALL be cleared to 0 by reset.
REQ-029 Without STREAM_DEMUX_CNT_EN, the cnt port and the counters SHALL be absent, and the rest of the behaviour SHALL be identical.

Structure
REQ-030 The package stream_demux_pkg SHALL hold the counter width constant (16) and the select-width helper function.
REQ-031 The per-channel register slot SHALL be the sub-module demux_slot, with parameter W and ports clk, rst_n, load, d, ready, q, valid; the top-level block SHALL instantiate it N times.

Verification
REQ-032 The bench SHALL cover this scenario: W=2, N=2, with the reset sequence then in_sel=0, in_data=2'b01, in_valid=1 for one cycle, and out_ready=2'b11 -> next cycle out_valid=2'b01, out_data=4'b0001, then out_valid=0.
REQ-033 The bench SHALL cover this scenario: channel 1 with out_ready[1]=0, sending 2'b10 then 2'b11 to channel 1 -> first word held stable, in_ready=0 on the second word until out_ready[1]=1, then 2'b11 delivered.
REQ-034 The bench SHALL cover this scenario: channel 0 stalled, then a send to channel 1 -> in_ready=1 and channel 1 valid 1 cycle later, with channel 0 unchanged.
REQ-035 The bench SHALL cover this scenario: N=3, in_sel=3, in_valid=1 -> in_ready=1, err_oob=1 next cycle, and no out_valid rises.
REQ-036 The bench SHALL cover this scenario: back-to-back 4 words to channel 0 with out_ready=1 -> 4 consecutive valid cycles, in order, with no bubbles.
REQ-037 The bench SHALL cover this scenario: rst_n pulled low mid-clock while channel 1 is holding data -> out_valid=0 and out_data=0 immediately; with CNT_EN defined, cnt=0 as well.
